// File: rtl/vga_pkg.sv
// Shared types and colour constants for the VGA cell renderer.
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COL_LIVE     = 24'hFFFFFF;
  localparam rgb_t COL_DEAD     = 24'h000000;
  localparam rgb_t COL_CUR_LIVE = 24'hFF0000;
  localparam rgb_t COL_CUR_DEAD = 24'h0000FF;
  localparam rgb_t COL_GRID     = 24'h404040;
  localparam rgb_t COL_BORDER   = 24'h202020;
  localparam rgb_t COL_BLANK    = 24'h000000;

  // Per-pixel attributes carried alongside the board read; hs/vs are pin levels.
  typedef struct packed {
    logic in_grid;
    logic in_vis;
    logic gline;
    logic hs;
    logic vs;
    logic fs;
  } side_t;

endpackage

// File: rtl/vga_timing_counter.sv
// Free-running h/v scan counters with raw sync and visible-area flags.
module vga_timing_counter #(
  parameter int WIDTH = 12,
  parameter int HSIZE = 640,
  parameter int HFP   = 656,
  parameter int HSP   = 752,
  parameter int HMAX  = 800,
  parameter int VSIZE = 480,
  parameter int VFP   = 490,
  parameter int VSP   = 492,
  parameter int VMAX  = 525,
  parameter bit HSPP  = 1'b0,
  parameter bit VSPP  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] o_hcnt,
  output logic [WIDTH-1:0] o_vcnt,
  output logic             o_line_end,
  output logic             o_vlast,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_in_vis
);

  localparam logic [WIDTH-1:0] H_LAST = WIDTH'(HMAX - 1);
  localparam logic [WIDTH-1:0] V_LAST = WIDTH'(VMAX - 1);
  localparam logic [WIDTH-1:0] H_VIS  = WIDTH'(HSIZE);
  localparam logic [WIDTH-1:0] V_VIS  = WIDTH'(VSIZE);
  localparam logic [WIDTH-1:0] H_FPE  = WIDTH'(HFP);
  localparam logic [WIDTH-1:0] H_SPE  = WIDTH'(HSP);
  localparam logic [WIDTH-1:0] V_FPE  = WIDTH'(VFP);
  localparam logic [WIDTH-1:0] V_SPE  = WIDTH'(VSP);

  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] r_vcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (o_line_end) begin
      r_hcnt <= '0;
      r_vcnt <= o_vlast ? '0 : r_vcnt + WIDTH'(1);
    end else begin
      r_hcnt <= r_hcnt + WIDTH'(1);
    end
  end

  assign o_hcnt     = r_hcnt;
  assign o_vcnt     = r_vcnt;
  assign o_line_end = (r_hcnt == H_LAST);
  assign o_vlast    = (r_vcnt == V_LAST);
  assign o_hsync    = (r_hcnt >= H_FPE && r_hcnt < H_SPE) ? HSPP : !HSPP;
  assign o_vsync    = (r_vcnt >= V_FPE && r_vcnt < V_SPE) ? VSPP : !VSPP;
  assign o_in_vis   = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);

endmodule

// File: rtl/vga_cell_renderer.sv
// Scans the screen, issues board read addresses and colours each scaled cell.
module vga_cell_renderer
  import vga_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int HSIZE      = 640,
  parameter int HFP        = 656,
  parameter int HSP        = 752,
  parameter int HMAX       = 800,
  parameter int VSIZE      = 480,
  parameter int VFP        = 490,
  parameter int VSP        = 492,
  parameter int VMAX       = 525,
  parameter bit HSPP       = 1'b0,
  parameter bit VSPP       = 1'b0,
  parameter int GRID_N     = 20,
  parameter int GRID_M     = 15,
  parameter int CELL_PX    = 32,
  parameter int RD_LAT     = 1,
  parameter bit GRID_LINES = 1'b0,
  parameter int ADDR_W     = $clog2(GRID_N * GRID_M)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cell_live,
  input  logic              cursor_en,
  input  logic [ADDR_W-1:0] cursor_pos,
  output logic [ADDR_W-1:0] cell_addr,
  output logic              hsync,
  output logic              vsync,
  output logic              data_enable,
  output logic [7:0]        video_red,
  output logic [7:0]        video_green,
  output logic [7:0]        video_blue,
  output logic              frame_start
);

  localparam int GW = GRID_N * CELL_PX;
  localparam int GH = GRID_M * CELL_PX;
  localparam int CW = $clog2(GRID_N + 1);
  localparam int RW = $clog2(GRID_M + 1);
  localparam int SW = $clog2(CELL_PX);
  localparam logic [SW-1:0] SUB_LAST = SW'(CELL_PX - 1);
  localparam side_t SIDE_IDLE = '{in_grid: 1'b0, in_vis: 1'b0, gline: 1'b0,
                                  hs: !HSPP, vs: !VSPP, fs: 1'b0};

  logic [WIDTH-1:0] w_hcnt, w_vcnt;
  logic             w_line_end, w_vlast, w_hsync, w_vsync, w_in_vis;

  vga_timing_counter #(
    .WIDTH(WIDTH), .HSIZE(HSIZE), .HFP(HFP), .HSP(HSP), .HMAX(HMAX),
    .VSIZE(VSIZE), .VFP(VFP), .VSP(VSP), .VMAX(VMAX), .HSPP(HSPP), .VSPP(VSPP)
  ) u_timing (
    .clk(clk), .rst_n(rst_n), .o_hcnt(w_hcnt), .o_vcnt(w_vcnt),
    .o_line_end(w_line_end), .o_vlast(w_vlast), .o_hsync(w_hsync),
    .o_vsync(w_vsync), .o_in_vis(w_in_vis)
  );

  logic [SW-1:0] r_hsub, r_vsub;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // Sub-counters track hcnt/vcnt mod CELL_PX so no divider is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsub <= '0;
      r_col  <= '0;
      r_vsub <= '0;
      r_row  <= '0;
    end else if (w_line_end) begin
      r_hsub <= '0;
      r_col  <= '0;
      if (w_vlast) begin
        r_vsub <= '0;
        r_row  <= '0;
      end else if (w_vcnt < WIDTH'(GH)) begin
        if (r_vsub == SUB_LAST) begin
          r_vsub <= '0;
          r_row  <= r_row + RW'(1);
        end else begin
          r_vsub <= r_vsub + SW'(1);
        end
      end
    end else if (w_hcnt < WIDTH'(GW)) begin
      if (r_hsub == SUB_LAST) begin
        r_hsub <= '0;
        r_col  <= r_col + CW'(1);
      end else begin
        r_hsub <= r_hsub + SW'(1);
      end
    end
  end

  logic              w_in_grid;
  logic [ADDR_W-1:0] w_addr;
  side_t             w_side;

  assign w_in_grid = (w_hcnt < WIDTH'(GW)) && (w_vcnt < WIDTH'(GH));
  assign w_addr    = w_in_grid ? (ADDR_W'(r_row) * ADDR_W'(GRID_N) + ADDR_W'(r_col)) : '0;
  assign w_side    = '{in_grid: w_in_grid,
                       in_vis:  w_in_vis,
                       gline:   GRID_LINES && (r_hsub == '0 || r_vsub == '0),
                       hs:      w_hsync,
                       vs:      w_vsync,
                       fs:      (w_hcnt == '0) && (w_vcnt == '0)};

  // Slot 0 is the registered address stage; the last slot lines up with cell_live.
  side_t             r_pipe  [RD_LAT];
  logic [ADDR_W-1:0] r_apipe [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe[i]  <= SIDE_IDLE;
        r_apipe[i] <= '0;
      end
    end else begin
      r_pipe[0]  <= w_side;
      r_apipe[0] <= w_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe[i]  <= r_pipe[i-1];
        r_apipe[i] <= r_apipe[i-1];
      end
    end
  end

  assign cell_addr = r_apipe[0];

  side_t             w_al;
  logic [ADDR_W-1:0] w_al_addr;
  rgb_t              w_rgb;

  assign w_al      = r_pipe[RD_LAT-1];
  assign w_al_addr = r_apipe[RD_LAT-1];

  always_comb begin
    w_rgb = COL_BLANK;
    if (!w_al.in_vis)                                 w_rgb = COL_BLANK;
    else if (!w_al.in_grid)                           w_rgb = COL_BORDER;
    else if (cursor_en && (cursor_pos == w_al_addr))  w_rgb = cell_live ? COL_CUR_LIVE : COL_CUR_DEAD;
    else if (w_al.gline)                              w_rgb = COL_GRID;
    else                                              w_rgb = cell_live ? COL_LIVE : COL_DEAD;
  end

  rgb_t r_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb       <= COL_BLANK;
      data_enable <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= !HSPP;
      vsync       <= !VSPP;
    end else begin
      r_rgb       <= w_rgb;
      data_enable <= w_al.in_vis;
      frame_start <= w_al.fs;
      hsync       <= w_al.hs;
      vsync       <= w_al.vs;
    end
  end

  assign video_red   = r_rgb.r;
  assign video_green = r_rgb.g;
  assign video_blue  = r_rgb.b;

endmodule

// File: tb/tb_vga_cell_renderer.sv
// Bench: five renderer instances (RD_LAT 1..4, grid lines on/off) checked against a pixel-coordinate model.
module tb_vga_cell_renderer;

  localparam int NCFG    = 5;
  localparam int HSIZE   = 16;
  localparam int HFP     = 18;
  localparam int HSP     = 20;
  localparam int HMAX    = 24;
  localparam int VSIZE   = 8;
  localparam int VFP     = 9;
  localparam int VSP     = 10;
  localparam int VMAX    = 12;
  localparam int GRID_N  = 4;
  localparam int GRID_M  = 2;
  localparam int CELL_PX = 3;

  function automatic int lat_of(int k);
    case (k)
      0:       return 2;
      1:       return 1;
      2:       return 3;
      3:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic bit gl_of(int k);
    return (k == 4);
  endfunction

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cursor_en  = 1'b0;
  logic [2:0] cursor_pos = 3'd0;
  logic       mem [8];

  logic [2:0] addr_o [NCFG];
  logic       hs_o   [NCFG];
  logic       vs_o   [NCFG];
  logic       de_o   [NCFG];
  logic       fs_o   [NCFG];
  logic [7:0] r_o    [NCFG];
  logic [7:0] g_o    [NCFG];
  logic [7:0] b_o    [NCFG];

  int n_cmp = 0;
  int n_bad = 0;
  int n_edge;
  bit chk_on = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_edge <= 0;
    else        n_edge <= n_edge + 1;
  end

  for (genvar k = 0; k < NCFG; k++) begin : g_dut
    localparam int L  = lat_of(k);
    localparam bit GL = gl_of(k);
    logic [2:0] lq [4];
    logic       live;

    // Board memory: address delayed RD_LAT-1 cycles, then read combinationally.
    always @(posedge clk) begin
      lq[0] <= addr_o[k];
      for (int i = 1; i < 4; i++) lq[i] <= lq[i-1];
    end
    if (L == 1) begin : g_l1
      assign live = mem[addr_o[k]];
    end else begin : g_ln
      assign live = mem[lq[L-2]];
    end

    vga_cell_renderer #(
      .HSIZE(HSIZE), .HFP(HFP), .HSP(HSP), .HMAX(HMAX),
      .VSIZE(VSIZE), .VFP(VFP), .VSP(VSP), .VMAX(VMAX),
      .GRID_N(GRID_N), .GRID_M(GRID_M), .CELL_PX(CELL_PX),
      .RD_LAT(L), .GRID_LINES(GL)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .cell_live(live),
      .cursor_en(cursor_en), .cursor_pos(cursor_pos),
      .cell_addr(addr_o[k]), .hsync(hs_o[k]), .vsync(vs_o[k]),
      .data_enable(de_o[k]), .video_red(r_o[k]), .video_green(g_o[k]),
      .video_blue(b_o[k]), .frame_start(fs_o[k])
    );
  end

  // ---------------- model ----------------
  // c is the scan index (pixel number since reset release); negative means "not yet reached".
  function automatic logic [23:0] exp_rgb(int c, bit gl);
    int h, v, a;
    logic live;
    if (c < 0) return 24'h000000;
    h = c % HMAX;
    v = (c / HMAX) % VMAX;
    if (!(h < HSIZE && v < VSIZE)) return 24'h000000;
    if (!(h < GRID_N * CELL_PX && v < GRID_M * CELL_PX)) return 24'h202020;
    a = (v / CELL_PX) * GRID_N + h / CELL_PX;
    live = mem[a];
    if (cursor_en && int'(cursor_pos) == a) return live ? 24'hFF0000 : 24'h0000FF;
    if (gl && (h % CELL_PX == 0 || v % CELL_PX == 0)) return 24'h404040;
    return live ? 24'hFFFFFF : 24'h000000;
  endfunction

  function automatic logic exp_hs(int c);
    int h;
    if (c < 0) return 1'b1;
    h = c % HMAX;
    return !(h >= HFP && h < HSP);
  endfunction

  function automatic logic exp_vs(int c);
    int v;
    if (c < 0) return 1'b1;
    v = (c / HMAX) % VMAX;
    return !(v >= VFP && v < VSP);
  endfunction

  function automatic logic exp_de(int c);
    if (c < 0) return 1'b0;
    return ((c % HMAX) < HSIZE) && (((c / HMAX) % VMAX) < VSIZE);
  endfunction

  function automatic logic exp_fs(int c);
    if (c < 0) return 1'b0;
    return (c % (HMAX * VMAX)) == 0;
  endfunction

  function automatic logic [2:0] exp_addr(int c);
    int h, v;
    if (c < 0) return 3'd0;
    h = c % HMAX;
    v = (c / HMAX) % VMAX;
    if (!(h < GRID_N * CELL_PX && v < GRID_M * CELL_PX)) return 3'd0;
    return 3'((v / CELL_PX) * GRID_N + h / CELL_PX);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int k, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d n=%0d: got %06h expected %06h", name, k, n_edge, act, exp);
    end
  endtask

  always @(negedge clk) begin : p_compare
    int c, ca;
    if (chk_on) begin
      for (int k = 0; k < NCFG; k++) begin
        c  = rst_n ? (n_edge - 1 - lat_of(k)) : -1;
        ca = rst_n ? (n_edge - 1) : -1;
        check("rgb",         k, {r_o[k], g_o[k], b_o[k]}, exp_rgb(c, gl_of(k)));
        check("hsync",       k, 24'(hs_o[k]),   24'(exp_hs(c)));
        check("vsync",       k, 24'(vs_o[k]),   24'(exp_vs(c)));
        check("data_enable", k, 24'(de_o[k]),   24'(exp_de(c)));
        check("frame_start", k, 24'(fs_o[k]),   24'(exp_fs(c)));
        check("cell_addr",   k, 24'(addr_o[k]), 24'(exp_addr(ca)));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic enter_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
  endtask

  task automatic leave_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (n_edge < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("run_to_timeout", 0, 24'(n_edge), 24'(target));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_mem();
    for (int i = 0; i < 4; i++) begin
      repeat (1) @(negedge clk);
    end
    chk_on = 1'b1;
    #2 rst_n = 1'b1;

    // All dead: first frame pulse, border, sync placement.
    run_to(2);
    check("lit_fs_n2_lat2", 0, 24'(fs_o[0]), 24'd0);
    check("lit_fs_n2_lat1", 1, 24'(fs_o[1]), 24'd1);
    run_to(3);
    check("lit_fs_n3_lat2", 0, 24'(fs_o[0]), 24'd1);
    check("lit_de_n3_lat2", 0, 24'(de_o[0]), 24'd1);
    run_to(15);
    check("lit_border_h12", 0, {r_o[0], g_o[0], b_o[0]}, 24'h202020);
    run_to(21);
    check("lit_hsync_h18", 0, 24'(hs_o[0]), 24'd0);
    run_to(23);
    check("lit_hsync_h20", 0, 24'(hs_o[0]), 24'd1);
    run_to(219);
    check("lit_vsync_v9", 0, 24'(vs_o[0]), 24'd0);
    run_to(300);

    // Cell 5 live.
    enter_reset();
    mem[5] = 1'b1;
    leave_reset();
    run_to(73);
    check("lit_addr_h0v3", 0, 24'(addr_o[0]), 24'd4);
    run_to(76);
    check("lit_addr_h3v3", 0, 24'(addr_o[0]), 24'd5);
    run_to(79);
    check("lit_addr_h6v3", 0, 24'(addr_o[0]), 24'd6);
    run_to(101);
    check("lit_dead_h2v4", 0, {r_o[0], g_o[0], b_o[0]}, 24'h000000);
    run_to(102);
    check("lit_gline_h3v4", 4, {r_o[4], g_o[4], b_o[4]}, 24'h404040);
    run_to(103);
    check("lit_live_h4v4", 0, {r_o[0], g_o[0], b_o[0]}, 24'hFFFFFF);
    check("lit_live_gl_h4v4", 4, {r_o[4], g_o[4], b_o[4]}, 24'hFFFFFF);
    run_to(300);

    // Cursor on live cell 5.
    enter_reset();
    cursor_en  = 1'b1;
    cursor_pos = 3'd5;
    leave_reset();
    run_to(102);
    check("lit_cur_over_gline", 4, {r_o[4], g_o[4], b_o[4]}, 24'hFF0000);
    run_to(103);
    check("lit_cur_live", 0, {r_o[0], g_o[0], b_o[0]}, 24'hFF0000);
    run_to(300);

    // Cursor on dead cell 5, cells 2 and 7 live; two frames to cross the wrap.
    enter_reset();
    mem[5] = 1'b0;
    mem[2] = 1'b1;
    mem[7] = 1'b1;
    leave_reset();
    run_to(10);
    check("lit_live_c2_h7v0", 0, {r_o[0], g_o[0], b_o[0]}, 24'hFFFFFF);
    check("lit_gline_c2_h7v0", 4, {r_o[4], g_o[4], b_o[4]}, 24'h404040);
    run_to(34);
    check("lit_live_gl_h7v1", 4, {r_o[4], g_o[4], b_o[4]}, 24'hFFFFFF);
    run_to(103);
    check("lit_cur_dead", 0, {r_o[0], g_o[0], b_o[0]}, 24'h0000FF);
    run_to(600);

    // Asynchronous reset mid-line with the counters at h=7, v=4.
    enter_reset();
    leave_reset();
    run_to(103);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NCFG; k++) begin
      check("async_rgb",  k, {r_o[k], g_o[k], b_o[k]}, 24'h000000);
      check("async_de",   k, 24'(de_o[k]),   24'd0);
      check("async_hs",   k, 24'(hs_o[k]),   24'd1);
      check("async_addr", k, 24'(addr_o[k]), 24'd0);
    end
    leave_reset();
    run_to(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
